control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Resetn  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  level; permits fetching the next instruction.
REQ-004 IR  input  32  instruction register contents: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
REQ-005 PCout, Zhighout, Zlowout, MDRout, HIout, LOout  output  1 each  bus-drive enables to datapath.
REQ-006 PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read  output  1 each  register-load and memory controls to datapath.
REQ-007 Rin, Rout  output  16 each  one-hot general-register load and drive selects.
REQ-008 opcode  output  5  ALU operation select.
REQ-009 Done  output  1  one-cycle pulse in an instruction's final state.
REQ-010 Illegal  output  1  one-cycle pulse on an undefined opcode.
REQ-011 Run  output  1  high whenever the state is not IDLE or HALT.

Function
REQ-012 Moore FSM: every output SHALL be decoded from the state register only; one state per clock.
REQ-013 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, and HALT (HALT only when CU_HALT_EN is defined).
REQ-014 IDLE->T0 when Start=1; otherwise remain in IDLE.
REQ-015 T0: PCout, MARin, IncPC, Zin.
REQ-016 T1: Zlowout, PCin, Read, MDRin; memory data is valid within T1 and is captured at the end of T1.
REQ-017 T2: MDRout, IRin; IR SHALL be decoded in T3 and later states only, never in T2.
REQ-018 Three-register class (IR[31:27] in 00011..01110): T3 Rout[Rb] and Yin; T4 Rout[Rc], Zin, opcode=IR[31:27]; T5 Zlowout and Rin[Ra] with Done.
REQ-019 MUL (01111) and DIV (10000): T3 Rout[Ra] and Yin; T4 Rout[Rb], Zin, opcode=IR[31:27]; T5 Zlowout and LOin; T6 Zhighout, HIin, Done.
REQ-020 NEG (10001) and NOT (10010): T3 Rout[Rb], Zin, opcode=IR[31:27]; T4 Zlowout, Rin[Ra], Done.
REQ-021 NOP (11010): Done in T3, with no register writes.
REQ-022 Any other opcode: Illegal and Done in T3, with no register writes.
REQ-023 Final state transitions SHALL go to T0 if Start=1, else IDLE.
REQ-024 opcode output SHALL be 00000 in every state except the ALU-evaluation state.
REQ-025 Rin and Rout SHALL be all-zero or exactly one-hot, and never both nonzero in the same cycle.
REQ-026 At most one bus-drive output (including Rout) SHALL be active per cycle.
REQ-027 Start deasserting mid-instruction SHALL NOT abort the instruction; it is sampled only in IDLE and final states.
REQ-028 Ra=Rb=Rc SHALL be legal; sequencing is unchanged.

Reset
REQ-029 Resetn=0 SHALL force IDLE immediately, regardless of Clock, including mid-instruction.
REQ-030 While in reset, all outputs SHALL be 0, including Rin=0, Rout=0, opcode=00000, Done=0, Illegal=0, and Run=0.
REQ-031 The first rising edge after Resetn rises SHALL evaluate the IDLE transition.

Configuration
REQ-032 Macro CU_HALT_EN defined: opcode 11011 SHALL enter HALT after T3, pulse Done in T3, drive all outputs 0 in HALT, and leave HALT only via Resetn.
REQ-033 Macro CU_HALT_EN undefined: HALT state SHALL be absent and opcode 11011 SHALL be treated as illegal (REQ-022).

Verification
REQ-034 Reset, Start=1, IR=32'h28918000 -> T0..T5 over 6 cycles; T3 Rout=0x0004 with Yin; T4 Rout=0x0008 with opcode=00101; T5 Rin=0x0002 with Done.
REQ-035 IR=32'h5B300000 (opcode 01011, Ra=6, Rb=6, Rc=0) -> T3 Rout=0x0040; T4 Rout=0x0001 with opcode=01011; T5 Rin=0x0040 with Done.
REQ-036 IR opcode 01111, Ra=2, Rb=3 -> T5 Zlowout with LOin; T6 Zhighout with HIin and Done; Rin=0 throughout.
REQ-037 IR opcode 11111 -> Illegal=1 and Done=1 in T3 only; next state T0 (Start=1), no Rin activity.
REQ-038 Resetn pulsed low in T4 -> all outputs 0 immediately; IDLE; with Start=1, refetch begins at T0 on the next edge.
REQ-039 With CU_HALT_EN, opcode 11011 -> HALT entered, Run=0, and the state is held for 20 cycles with Start=1; without the macro -> Illegal pulse instead.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2) then opcode-dependent execute (T3-T6).
// Optional HALT state for opcode 11011 is built only when CU_HALT_EN is defined.
module control_sequencer (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [31:0] IR,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  opcode,
  output logic        Done,
  output logic        Illegal,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
`ifdef CU_HALT_EN
    S_T6,
    S_HALT
`else
    S_T6
`endif
  } state_t;

  state_t state_q, state_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       cls_3reg, cls_muldiv, cls_unary, cls_nop, cls_halt;
  logic       ir_unused;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign ir_unused = ^IR[14:0];

  assign cls_3reg   = (op >= 5'd3) && (op <= 5'd14);
  assign cls_muldiv = (op == 5'd15) || (op == 5'd16);
  assign cls_unary  = (op == 5'd17) || (op == 5'd18);
  assign cls_nop    = (op == 5'd26);
`ifdef CU_HALT_EN
  assign cls_halt   = (op == 5'd27);
`else
  assign cls_halt   = 1'b0;
`endif

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'd1 << idx;
  endfunction

  // Final states share one exit: refetch if Start is held, otherwise idle.
  state_t exit_state;
  assign exit_state = Start ? S_T0 : S_IDLE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (Start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        if (cls_3reg || cls_muldiv || cls_unary) state_d = S_T4;
`ifdef CU_HALT_EN
        else if (cls_halt)                       state_d = S_HALT;
`endif
        else                                     state_d = exit_state;
      end
      S_T4:   state_d = cls_unary ? exit_state : S_T5;
      S_T5:   state_d = cls_muldiv ? S_T6 : exit_state;
      S_T6:   state_d = exit_state;
`ifdef CU_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // IR is a datapath register loaded at the end of T2, so it is only looked at from T3 on.
  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    HIout    = 1'b0;
    LOout    = 1'b0;
    PCin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = 16'd0;
    Rout     = 16'd0;
    opcode   = 5'd0;
    Done     = 1'b0;
    Illegal  = 1'b0;
    Run      = (state_q != S_IDLE);
`ifdef CU_HALT_EN
    if (state_q == S_HALT) Run = 1'b0;
`endif
    case (state_q)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (cls_3reg) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
        end else if (cls_muldiv) begin
          Rout = onehot(ra);
          Yin  = 1'b1;
        end else if (cls_unary) begin
          Rout   = onehot(rb);
          Zin    = 1'b1;
          opcode = op;
        end else begin
          Done    = 1'b1;
          Illegal = !cls_nop && !cls_halt;
        end
      end
      S_T4: begin
        if (cls_unary) begin
          Zlowout = 1'b1;
          Rin     = onehot(ra);
          Done    = 1'b1;
        end else begin
          Rout   = cls_3reg ? onehot(rc) : onehot(rb);
          Zin    = 1'b1;
          opcode = op;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin  = onehot(ra);
          Done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        Done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed literal checks, then randomized
// instructions against a queue-based model of per-cycle control words. Honors CU_HALT_EN.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Resetn, Start;
  logic [31:0] IR;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read;
  logic [15:0] Rin, Rout;
  logic [4:0]  opcode;
  logic        Done, Illegal, Run;

  control_sequencer dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .IR(IR),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
    .Read(Read), .Rin(Rin), .Rout(Rout), .opcode(opcode), .Done(Done),
    .Illegal(Illegal), .Run(Run)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out;
    logic        pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, inc_pc, read;
    logic [15:0] rin, rout;
    logic [4:0]  opc;
    logic        done, illegal, run;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, IncPC, Read,
                  Rin, Rout, opcode, Done, Illegal, Run};

  int vectors = 0;
  int miscompares = 0;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_HALT = 3;
  int          phase;
  bit          halt_after;
  outs_t       q[$];
  logic [31:0] next_ir;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic outs_t run_only();
    outs_t e = '0;
    e.run = 1'b1;
    return e;
  endfunction

  function automatic outs_t expected();
    outs_t e = '0;
    if ((phase == PH_FETCH || phase == PH_EXEC) && q.size() > 0) e = q[0];
    return e;
  endfunction

  task automatic model_reset();
    phase = PH_IDLE;
    halt_after = 1'b0;
    q.delete();
  endtask

  task automatic load_fetch();
    outs_t e;
    q.delete();
    e = run_only(); e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; q.push_back(e);
    e = run_only(); e.zlo_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1; q.push_back(e);
    e = run_only(); e.mdr_out = 1; e.ir_in = 1; q.push_back(e);
    phase = PH_FETCH;
  endtask

  task automatic load_exec(input logic [31:0] ir);
    outs_t e;
    int op, ra, rb, rc;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    halt_after = 1'b0;
    q.delete();
    if (op >= 3 && op <= 14) begin
      e = run_only(); e.rout = 16'd1 << rb; e.y_in = 1; q.push_back(e);
      e = run_only(); e.rout = 16'd1 << rc; e.z_in = 1; e.opc = 5'(op); q.push_back(e);
      e = run_only(); e.zlo_out = 1; e.rin = 16'd1 << ra; e.done = 1; q.push_back(e);
    end else if (op == 15 || op == 16) begin
      e = run_only(); e.rout = 16'd1 << ra; e.y_in = 1; q.push_back(e);
      e = run_only(); e.rout = 16'd1 << rb; e.z_in = 1; e.opc = 5'(op); q.push_back(e);
      e = run_only(); e.zlo_out = 1; e.lo_in = 1; q.push_back(e);
      e = run_only(); e.zhi_out = 1; e.hi_in = 1; e.done = 1; q.push_back(e);
    end else if (op == 17 || op == 18) begin
      e = run_only(); e.rout = 16'd1 << rb; e.z_in = 1; e.opc = 5'(op); q.push_back(e);
      e = run_only(); e.zlo_out = 1; e.rin = 16'd1 << ra; e.done = 1; q.push_back(e);
    end else if (op == 26) begin
      e = run_only(); e.done = 1; q.push_back(e);
`ifdef CU_HALT_EN
    end else if (op == 27) begin
      e = run_only(); e.done = 1; q.push_back(e);
      halt_after = 1'b1;
`endif
    end else begin
      e = run_only(); e.done = 1; e.illegal = 1; q.push_back(e);
    end
    phase = PH_EXEC;
  endtask

  task automatic model_update();
    if (phase == PH_IDLE) begin
      if (Start) load_fetch();
    end else if (phase != PH_HALT) begin
      void'(q.pop_front());
      if (q.size() == 0) begin
        if (phase == PH_FETCH)  load_exec(IR);
        else if (halt_after)    phase = PH_HALT;
        else if (Start)         load_fetch();
        else                    phase = PH_IDLE;
      end
    end
  endtask

  // Called at a falling edge: IR is garbage except from T2 onward, where the fetched word appears.
  task automatic tick();
    if (phase == PH_FETCH && q.size() == 1) IR = next_ir;
    else if (phase != PH_EXEC)              IR = $urandom();
    @(posedge Clock);
    model_update();
    @(negedge Clock);
    chk("outputs", 64'(dut_o), 64'(expected()));
  endtask

  task automatic pulse_reset();
    Resetn = 1'b0;
    #1;
    chk("reset_outputs", 64'(dut_o), 64'd0);
    model_reset();
    #2 Resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [4:0]  op;
    r  = $urandom();
    op = 5'($urandom_range(0, 31));
    r[31:27] = op;
    if ($urandom_range(0, 3) == 0) begin
      r[22:19] = r[26:23];
      r[18:15] = r[26:23];
    end
    return r;
  endfunction

  initial begin
    Resetn = 1'b0; Start = 1'b0; IR = 32'd0; next_ir = 32'd0;
    model_reset();
    repeat (3) @(negedge Clock);
    chk("in_reset", 64'(dut_o), 64'd0);
    Resetn = 1'b1;

    Start = 1'b1; next_ir = 32'h28918000;
    tick(); chk("t0_pcout", 64'(PCout), 64'd1);
    tick(); tick(); tick();
    chk("t3_rout", 64'(Rout), 64'h0004); chk("t3_yin", 64'(Yin), 64'd1);
    tick(); chk("t4_rout", 64'(Rout), 64'h0008); chk("t4_opcode", 64'(opcode), 64'h05);
    tick(); chk("t5_rin", 64'(Rin), 64'h0002); chk("t5_done", 64'(Done), 64'd1);

    next_ir = 32'h5B300000;
    repeat (4) tick();
    chk("same_t3_rout", 64'(Rout), 64'h0040);
    tick(); chk("same_t4_rout", 64'(Rout), 64'h0001); chk("same_t4_opc", 64'(opcode), 64'h0B);
    tick(); chk("same_t5_rin", 64'(Rin), 64'h0040); chk("same_t5_done", 64'(Done), 64'd1);

    next_ir = {5'b01111, 4'd2, 4'd3, 4'd0, 15'd0};
    repeat (4) tick(); chk("mul_t3_rout", 64'(Rout), 64'h0004);
    tick(); chk("mul_t4_rout", 64'(Rout), 64'h0008);
    tick(); chk("mul_t5_lo", 64'({Zlowout, LOin, Done}), 64'b110); chk("mul_t5_rin", 64'(Rin), 64'd0);
    tick(); chk("mul_t6_hi", 64'({Zhighout, HIin, Done}), 64'b111); chk("mul_t6_rin", 64'(Rin), 64'd0);

    next_ir = 32'hF8000000;
    repeat (4) tick(); chk("ill_t3", 64'({Illegal, Done, Rin}), {46'd0, 2'b11, 16'd0});
    tick(); chk("ill_next_t0", 64'({Illegal, PCout}), 64'b01);

    next_ir = 32'h28918000;
    repeat (4) tick(); chk("rst_at_t4_opc", 64'(opcode), 64'h05);
    pulse_reset();
    chk("rst_run", 64'(Run), 64'd0);
    tick(); chk("rst_refetch_t0", 64'(PCout), 64'd1);

    next_ir = {5'b11011, 27'd0};
    repeat (3) tick(); chk("op27_t3_done", 64'(Done), 64'd1);
`ifdef CU_HALT_EN
    chk("op27_t3_illegal", 64'(Illegal), 64'd0);
    tick(); chk("halt_run", 64'(Run), 64'd0);
    repeat (20) tick();
    chk("halt_held", 64'(dut_o), 64'd0);
    pulse_reset();
`else
    chk("op27_t3_illegal", 64'(Illegal), 64'd1);
`endif

    for (int i = 0; i < 2500; i++) begin
      Start = ($urandom_range(0, 99) < 80);
      if (phase == PH_FETCH && q.size() == 1) next_ir = rand_ir();
      if ($urandom_range(0, 99) < ((phase == PH_HALT) ? 10 : 1)) pulse_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
